// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit DDR2 test-pattern LFSR: width, seed, step function, checker states.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'h1f;

  typedef enum logic [1:0] {
    SEEK,
    VERIFY,
    LOCKED
  } chk_state_e;

  // One pattern step; generator and checker must use this same function.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] d);
    logic [LFSR_W-1:0] n;
    n[4] = d[4] ^ d[1];
    n[3] = d[3] ^ d[0];
    n[2] = d[2] ^ n[4];
    n[1] = d[1] ^ n[3];
    n[0] = d[0] ^ n[2];
    return n;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive-side checker bus: pattern word in, lock/error status out.
// LFSR_CHK_STATS_EN adds the match_cnt statistic.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  import lfsr_pkg::*;

  logic [LFSR_W-1:0] data_in;
  logic              valid_in;
  logic              clr;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;
`ifdef LFSR_CHK_STATS_EN
  logic [ERR_W-1:0]  match_cnt;

  modport master (output data_in, valid_in, clr,
                  input  locked, err_pulse, err_cnt, match_cnt);
  modport slave  (input  data_in, valid_in, clr,
                  output locked, err_pulse, err_cnt, match_cnt);
`else
  modport master (output data_in, valid_in, clr,
                  input  locked, err_pulse, err_cnt);
  modport slave  (input  data_in, valid_in, clr,
                  output locked, err_pulse, err_cnt);
`endif

endinterface

// File: rtl/lfsr_checker.sv
// Self-seeding LFSR stream checker: SEEK -> VERIFY -> LOCKED, saturating error statistics.
// Define LFSR_CHK_STATS_EN to add a saturating count of locked matches (match_cnt).
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  // One run counter serves both VERIFY match runs and LOCKED miss runs.
  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_CNT - 1);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [ERR_W-1:0] CNT_ONE   = ERR_W'(1);

  chk_state_e        state;
  logic [LFSR_W-1:0] expected;
  logic [RUN_W-1:0]  run;
  logic              locked_q;
  logic              err_pulse_q;
  logic [ERR_W-1:0]  err_cnt_q;

  wire word_match = (bus.data_in == expected);
  wire word_zero  = (bus.data_in == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEEK;
      expected    <= LFSR_SEED;
      run         <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.clr) err_cnt_q <= '0;
      if (bus.valid_in) begin
        unique case (state)
          SEEK: begin
            if (!word_zero) begin
              expected <= lfsr_step(bus.data_in);
              run      <= '0;
              state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (word_match) begin
              expected <= lfsr_step(expected);
              if (run == LOCK_LAST) begin
                run      <= '0;
                state    <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                run <= run + RUN_ONE;
              end
            end else if (!word_zero) begin
              // Mismatch reseeds from the offending word straight away.
              expected <= lfsr_step(bus.data_in);
              run      <= '0;
            end else begin
              run   <= '0;
              state <= SEEK;
            end
          end
          LOCKED: begin
            expected <= lfsr_step(expected);
            if (word_match) begin
              run <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (!bus.clr && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
              if (run == LOSS_LAST) begin
                run      <= '0;
                state    <= SEEK;
                locked_q <= 1'b0;
              end else begin
                run <= run + RUN_ONE;
              end
            end
          end
          default: begin
            run   <= '0;
            state <= SEEK;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;

`ifdef LFSR_CHK_STATS_EN
  logic [ERR_W-1:0] match_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      match_cnt_q <= '0;
    end else if (bus.valid_in && state == LOCKED && word_match && match_cnt_q != '1) begin
      match_cnt_q <= match_cnt_q + CNT_ONE;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker against a mode/counter reference model of the stream checker.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int ERR_W    = 2;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(ERR_W)) bus ();

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = seek, 1 = verify, 2 = locked
  int       m_mode;
  bit [4:0] m_exp;
  int       m_run;
  int       m_err;
  int       m_match;
  bit       m_lock;
  bit       m_pulse;

  // Same recurrence, each next bit expanded to XORs of the current bits.
  function automatic bit [4:0] ref_step(bit [4:0] d);
    bit [4:0] n;
    n[4] = d[4] ^ d[1];
    n[3] = d[3] ^ d[0];
    n[2] = d[2] ^ d[4] ^ d[1];
    n[1] = d[1] ^ d[3] ^ d[0];
    n[0] = d[0] ^ d[2] ^ d[4] ^ d[1];
    return n;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(bit r, bit v, bit [4:0] d, bit c);
    if (r) begin
      m_mode = 0; m_exp = 5'h1f; m_run = 0; m_lock = 0; m_pulse = 0; m_err = 0; m_match = 0;
      return;
    end
    m_pulse = 0;
    if (c) begin m_err = 0; m_match = 0; end
    if (!v) return;
    case (m_mode)
      0: if (d != 0) begin m_exp = ref_step(d); m_run = 0; m_mode = 1; end
      1: begin
        if (d == m_exp) begin
          m_run++;
          m_exp = ref_step(m_exp);
          if (m_run == LOCK_CNT) begin m_mode = 2; m_run = 0; end
        end else if (d != 0) begin
          m_exp = ref_step(d); m_run = 0;
        end else begin
          m_mode = 0; m_run = 0;
        end
      end
      default: begin
        if (d == m_exp) begin
          m_run = 0;
          if (!c) m_match = sat_inc(m_match);
        end else begin
          m_pulse = 1;
          if (!c) m_err = sat_inc(m_err);
          m_run++;
          if (m_run == LOSS_CNT) begin m_mode = 0; m_run = 0; end
        end
        m_exp = ref_step(m_exp);
      end
    endcase
    m_lock = (m_mode == 2);
  endtask

  task automatic cyc(bit r, bit v, bit [4:0] d, bit c);
    rst          = r;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.clr      = c;
    @(posedge clk);
    model(r, v, d, c);
    #1;
    chk("locked",    int'(bus.locked),    int'(m_lock));
    chk("err_pulse", int'(bus.err_pulse), int'(m_pulse));
    chk("err_cnt",   int'(bus.err_cnt),   m_err);
`ifdef LFSR_CHK_STATS_EN
    chk("match_cnt", int'(bus.match_cnt), m_match);
`endif
  endtask

  bit [4:0] seq1 [5] = '{5'h1f, 5'h06, 5'h12, 5'h02, 5'h17};
  bit [4:0] seq4 [5] = '{5'h06, 5'h12, 5'h02, 5'h17, 5'h0c};

  initial begin
    rst = 1'b1; bus.valid_in = 1'b0; bus.data_in = '0; bus.clr = 1'b0;
    cyc(1, 0, 5'h00, 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_err",    int'(bus.err_cnt), 0);

    // Seed and lock from the reset seed sequence
    foreach (seq1[i]) cyc(0, 1, seq1[i], 0);
    chk("t1_locked", int'(bus.locked), 1);
    chk("t1_err",    int'(bus.err_cnt), 0);

    // Single bad word while locked, then back in sequence
    cyc(0, 1, 5'h00, 0);
    chk("t2_pulse", int'(bus.err_pulse), 1);
    cyc(0, 1, m_exp, 0);
    cyc(0, 1, m_exp, 0);
    chk("t2_err",    int'(bus.err_cnt), 1);
    chk("t2_locked", int'(bus.locked), 1);

    // Three consecutive misses drop lock; counter saturates at 3
    repeat (3) cyc(0, 1, m_exp ^ 5'h01, 0);
    chk("t3_err",    int'(bus.err_cnt), 3);
    chk("t3_locked", int'(bus.locked), 0);
    cyc(0, 1, 5'h1f, 0);
    chk("t3_reseed", m_mode, 1);

    // Zeros never seed
    cyc(1, 0, 5'h00, 0);
    cyc(0, 1, 5'h00, 0);
    cyc(0, 1, 5'h00, 0);
    foreach (seq4[i]) cyc(0, 1, seq4[i], 0);
    chk("t4_locked", int'(bus.locked), 1);

    // Clear coinciding with an error
    cyc(0, 1, m_exp ^ 5'h04, 0);
    cyc(0, 1, m_exp ^ 5'h04, 1);
    chk("t5_clr_err",   int'(bus.err_cnt), 0);
    chk("t5_clr_pulse", int'(bus.err_pulse), 1);
    cyc(0, 1, m_exp, 0);

    // Reset mid-LOCKED and mid-VERIFY with valid data present
    cyc(1, 1, m_exp, 0);
    chk("t6_rst_locked", int'(bus.locked), 0);
    cyc(0, 1, 5'h1f, 0);
    cyc(0, 1, 5'h06, 0);
    cyc(1, 1, 5'h12, 0);
    chk("t6_rst_verify", m_mode, 0);

    // Randomized traffic: mostly in-sequence words, some zeros and noise
    for (int n = 0; n < 3000; n++) begin
      bit       r, v, c;
      bit [4:0] d;
      int       pick;
      r    = ($urandom_range(199) == 0);
      v    = ($urandom_range(3) != 0);
      c    = ($urandom_range(29) == 0);
      pick = $urandom_range(99);
      if (pick < 75)      d = m_exp;
      else if (pick < 83) d = 5'h00;
      else                d = 5'($urandom);
      cyc(r, v, d, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
